dcache_port_arbiter: RTL and testbench

// - Shares the single-ported DCache tag/data array between three requesters:

---
 rtl/dcache_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// Single-port DCache array arbiter: refill bursts, loads and store drain, one registered access per cycle.
// Optional grant/stall performance counters are built when DCACHE_ARB_PERF_EN is defined.
module dcache_port_arbiter #(
  parameter int LINE_BEATS = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        refill_req,
  input  logic [27:0] refill_addr,
  input  logic [31:0] refill_data,
  output logic        refill_ready,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ready,
  input  logic        wb_half,
  input  logic        flush,
  output logic        st_line_loaded,
  output logic        arr_en,
  output logic        arr_we,
  output logic [1:0]  arr_src,
  output logic [31:0] arr_addr,
  output logic [31:0] arr_wdata,
  output logic [3:0]  arr_wstrb
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int BW = $clog2(LINE_BEATS);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  typedef struct packed {
    logic        we;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arr_req_t;

  logic [0:0]    state;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          st_forced, rf_gnt, ld_gnt, st_gnt, any_gnt;
  logic [3:0]    st_strb;
  arr_req_t      nxt, arr_q;

  assign st_forced = (starve_cnt == SW'(STARVE_MAX)) || wb_half;

  // Readies are gated by reset so every output reads 0 while resetn is low.
  always_comb begin
    refill_ready = 1'b0;
    ld_ready     = 1'b0;
    st_ready     = 1'b0;
    if (resetn) begin
      if (state == S_REFILL)       refill_ready = 1'b1;
      else if (refill_req)         refill_ready = 1'b1;
      else if (st_req && st_forced) st_ready    = 1'b1;
      else if (ld_req && !flush)   ld_ready     = 1'b1;
      else if (st_req)             st_ready     = 1'b1;
    end
  end

  assign rf_gnt  = refill_req & refill_ready;
  assign ld_gnt  = ld_req & ld_ready;
  assign st_gnt  = st_req & st_ready;
  assign any_gnt = rf_gnt | ld_gnt | st_gnt;
  assign st_line_loaded = ld_gnt & st_req & (ld_addr[31:4] == st_addr[31:4]);

  always_comb begin
    case (st_size)
      2'd0:    st_strb = 4'b0001 << st_addr[1:0];
      2'd1:    st_strb = st_addr[1] ? 4'b1100 : 4'b0011;
      default: st_strb = 4'b1111;
    endcase
  end

  always_comb begin
    nxt = '0;
    if (rf_gnt) begin
      nxt.we    = 1'b1;
      nxt.src   = 2'd2;
      nxt.addr  = {refill_addr, 4'b0000} + (32'(beat_cnt) << 2);
      nxt.wdata = refill_data;
      nxt.wstrb = 4'hF;
    end else if (st_gnt) begin
      nxt.we    = 1'b1;
      nxt.src   = 2'd1;
      nxt.addr  = st_addr;
      nxt.wdata = st_data;
      nxt.wstrb = st_strb;
    end else if (ld_gnt) begin
      nxt.addr  = ld_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      arr_en     <= 1'b0;
      arr_q      <= '0;
    end else begin
      arr_en <= any_gnt;
      if (any_gnt) arr_q <= nxt;
      // beat_cnt is 0 in IDLE, so the same step covers the burst-opening beat.
      if (rf_gnt) begin
        if (beat_cnt == BW'(LINE_BEATS - 1)) begin
          beat_cnt <= '0;
          state    <= S_IDLE;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
          state    <= S_REFILL;
        end
      end
      if (!st_req || st_gnt)                   starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))  starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign arr_we    = arr_q.we;
  assign arr_src   = arr_q.src;
  assign arr_addr  = arr_q.addr;
  assign arr_wdata = arr_q.wdata;
  assign arr_wstrb = arr_q.wstrb;

`ifdef DCACHE_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_ld_cnt    <= '0;
      perf_st_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (ld_gnt) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (st_gnt) perf_st_cnt <= perf_st_cnt + 32'd1;
      if ((refill_req | ld_req | st_req) && !any_gnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a transaction-level reference model checked every cycle.
module tb_dcache_port_arbiter;
  localparam int LINE_BEATS = 4;
  localparam int STARVE_MAX = 7;

  logic        clk, resetn;
  logic        refill_req, refill_ready, ld_req, ld_ready, st_req, st_ready;
  logic [27:0] refill_addr;
  logic [31:0] refill_data, ld_addr, st_addr, st_data;
  logic [1:0]  st_size;
  logic        wb_half, flush, st_line_loaded;
  logic        arr_en, arr_we;
  logic [1:0]  arr_src;
  logic [31:0] arr_addr, arr_wdata;
  logic [3:0]  arr_wstrb;

  int n_vec = 0;
  int n_err = 0;

  dcache_port_arbiter #(.LINE_BEATS(LINE_BEATS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_data(refill_data),
    .refill_ready(refill_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready), .wb_half(wb_half), .flush(flush),
    .st_line_loaded(st_line_loaded),
    .arr_en(arr_en), .arr_we(arr_we), .arr_src(arr_src), .arr_addr(arr_addr),
    .arr_wdata(arr_wdata), .arr_wstrb(arr_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: burst progress as beats remaining, store wait as a plain count.
  int          m_left, m_wait;
  logic        e_en, e_we;
  logic [1:0]  e_src;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_strb;
  logic        m_rf, m_ld, m_st;

  always_comb begin
    m_rf = 1'b0; m_ld = 1'b0; m_st = 1'b0;
    if (!resetn) ;
    else if (m_left > 0 || refill_req)                     m_rf = 1'b1;
    else if (st_req && (m_wait >= STARVE_MAX || wb_half))  m_st = 1'b1;
    else if (ld_req && !flush)                             m_ld = 1'b1;
    else if (st_req)                                       m_st = 1'b1;
  end

  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] a);
    int lo;
    lo = int'(a);
    case (sz)
      2'd0:    return 4'(1 << lo);
      2'd1:    return (lo >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0; m_wait <= 0;
      e_en <= 1'b0; e_we <= 1'b0; e_src <= 2'd0; e_addr <= '0; e_wdata <= '0; e_strb <= '0;
    end else begin
      automatic bit g_rf = refill_req && m_rf;
      automatic bit g_st = st_req && m_st;
      automatic bit g_ld = ld_req && m_ld;
      automatic int beat = (m_left > 0) ? LINE_BEATS - m_left : 0;
      e_en <= g_rf || g_st || g_ld;
      if (g_rf) begin
        e_we <= 1'b1; e_src <= 2'd2; e_strb <= 4'hF; e_wdata <= refill_data;
        e_addr <= {refill_addr, 4'h0} + 32'(beat * 4);
        m_left <= (m_left > 0) ? m_left - 1 : LINE_BEATS - 1;
      end else if (g_st) begin
        e_we <= 1'b1; e_src <= 2'd1; e_addr <= st_addr; e_wdata <= st_data;
        e_strb <= strb_of(st_size, st_addr[1:0]);
      end else if (g_ld) begin
        e_we <= 1'b0; e_src <= 2'd0; e_addr <= ld_addr; e_strb <= 4'h0;
      end
      if (st_req && !g_st) m_wait <= (m_wait < STARVE_MAX) ? m_wait + 1 : m_wait;
      else                 m_wait <= 0;
    end
  end

  bit mdl_on = 1'b0;
  always @(negedge clk) begin
    if (mdl_on) begin
      automatic logic e_sll = ld_req && m_ld && st_req && (ld_addr[31:4] == st_addr[31:4]);
      chk("m_refill_ready", 32'(refill_ready), 32'(m_rf));
      chk("m_ld_ready", 32'(ld_ready), 32'(m_ld));
      chk("m_st_ready", 32'(st_ready), 32'(m_st));
      chk("m_st_line_loaded", 32'(st_line_loaded), 32'(e_sll));
      chk("m_arr_en", 32'(arr_en), 32'(e_en));
      if (e_en || !resetn) begin
        chk("m_arr_we", 32'(arr_we), 32'(e_we));
        chk("m_arr_src", 32'(arr_src), 32'(e_src));
        chk("m_arr_addr", arr_addr, e_addr);
        chk("m_arr_wstrb", 32'(arr_wstrb), 32'(e_strb));
        if (e_we || !resetn) chk("m_arr_wdata", arr_wdata, e_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    refill_req = 0; ld_req = 0; st_req = 0; wb_half = 0; flush = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_refill_ready"}, 32'(refill_ready), 0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 0);
    chk({tag, "_st_ready"}, 32'(st_ready), 0);
    chk({tag, "_st_line_loaded"}, 32'(st_line_loaded), 0);
    chk({tag, "_arr_en"}, 32'(arr_en), 0);
    chk({tag, "_arr_we"}, 32'(arr_we), 0);
    chk({tag, "_arr_src"}, 32'(arr_src), 0);
    chk({tag, "_arr_addr"}, arr_addr, 0);
    chk({tag, "_arr_wdata"}, arr_wdata, 0);
    chk({tag, "_arr_wstrb"}, 32'(arr_wstrb), 0);
  endtask

  logic [1:0]  sz_t [6] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0]  a_t  [6] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [3:0]  s_t  [6] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1111};

  initial begin
    resetn = 0; idle_in();
    refill_addr = '0; refill_data = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_size = '0;
    refill_req = 1; ld_req = 1; st_req = 1;
    mdl_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    tick(); idle_in(); resetn = 1;

    // Lone load: same-cycle grant, read access the next cycle.
    ld_req = 1; ld_addr = 32'h1000_0004;
    @(negedge clk); chk("ld_ready", 32'(ld_ready), 1);
    tick(); ld_req = 0;
    @(negedge clk);
    chk("ld_arr_en", 32'(arr_en), 1); chk("ld_arr_we", 32'(arr_we), 0);
    chk("ld_arr_src", 32'(arr_src), 0); chk("ld_arr_addr", arr_addr, 32'h1000_0004);
    tick();

    // Refill burst blocks a held load until it ends.
    refill_req = 1; refill_addr = 28'h100_0000; ld_req = 1; ld_addr = 32'h1000_0040;
    for (int i = 0; i < 4; i++) begin
      refill_data = 32'hA0 + 32'(i);
      @(negedge clk);
      chk("rf_ld_blocked", 32'(ld_ready), 0);
      chk("rf_ready", 32'(refill_ready), 1);
      if (i > 0) chk("rf_addr", arr_addr, 32'h1000_0000 + 32'(4 * (i - 1)));
      tick();
    end
    refill_req = 0;
    @(negedge clk);
    chk("rf_last_addr", arr_addr, 32'h1000_000C);
    chk("rf_last_data", arr_wdata, 32'hA3);
    chk("rf_ld_resume", 32'(ld_ready), 1);
    tick();

    // Starvation: loads win 7 cycles, then the store is forced.
    st_req = 1; st_addr = 32'h3000_0000; st_data = 32'hDEAD_BEEF; st_size = 2'd2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("starve_ld_wins", 32'(ld_ready), 1);
      chk("starve_st_wait", 32'(st_ready), 0);
      tick();
    end
    @(negedge clk);
    chk("starve_st_forced", 32'(st_ready), 1); chk("starve_ld_held", 32'(ld_ready), 0);
    tick();
    @(negedge clk);
    chk("starve_cleared", 32'(ld_ready), 1);
    tick(); idle_in();

    // Store strobes.
    for (int i = 0; i < 6; i++) begin
      st_req = 1; st_size = sz_t[i]; st_addr = 32'h3000_0010 | 32'(a_t[i]); st_data = 32'h1111_0000 + 32'(i);
      tick(); st_req = 0;
      @(negedge clk);
      chk("st_wstrb", 32'(arr_wstrb), 32'(s_t[i]));
      chk("st_src", 32'(arr_src), 1);
    end
    tick();

    // Head-line detection on a granted load.
    ld_req = 1; ld_addr = 32'h2000_0010; st_req = 1; st_addr = 32'h2000_001C; st_size = 2'd2;
    @(negedge clk);
    chk("sll_ld_ready", 32'(ld_ready), 1); chk("sll_hit", 32'(st_line_loaded), 1);
    tick(); st_addr = 32'h2000_0020;
    @(negedge clk); chk("sll_miss", 32'(st_line_loaded), 0);
    tick(); wb_half = 1;
    @(negedge clk); chk("wb_half_st", 32'(st_ready), 1); chk("wb_half_ld", 32'(ld_ready), 0);
    tick(); idle_in();

    // Flush kills only this cycle's load grant.
    ld_req = 1; ld_addr = 32'h4000_0008;
    tick(); flush = 1;
    @(negedge clk);
    chk("flush_prev_ld_issues", 32'(arr_en), 1); chk("flush_ld_ready", 32'(ld_ready), 0);
    tick(); flush = 0; ld_req = 0;
    @(negedge clk); chk("flush_no_issue", 32'(arr_en), 0);
    tick(); flush = 1; ld_req = 1; st_req = 1; st_addr = 32'h4000_0100;
    @(negedge clk);
    chk("flush_st_ready", 32'(st_ready), 1); chk("flush_ld_killed", 32'(ld_ready), 0);
    tick(); idle_in();

    // Reset in the middle of a burst restarts the line from beat 0.
    refill_req = 1; refill_addr = 28'h200_0000; refill_data = 32'h55;
    tick(); tick();
    resetn = 0;
    @(negedge clk);
    chk_all_zero("midrst");
    tick(); resetn = 1;
    @(negedge clk); chk("rst_rf_ready", 32'(refill_ready), 1);
    tick();
    @(negedge clk); chk("rst_rf_beat0", arr_addr, 32'h2000_0000);
    tick(); tick(); tick(); refill_req = 0;
    @(negedge clk); chk("rst_rf_beat3", arr_addr, 32'h2000_000C);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
